// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle controller.
package legv8_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXEC_R    = 4'd3,
      S_WB_R      = 4'd4,
      S_EXEC_ADDR = 4'd5,
      S_MEM_RD    = 4'd6,
      S_WB_LD     = 4'd7,
      S_MEM_WR    = 4'd8,
      S_BRANCH    = 4'd9,
      S_CBZ_EVAL  = 4'd10,
      S_TRAP      = 4'd11
   } state_e;

   typedef enum logic [2:0] {
      C_ILLEGAL = 3'd0,
      C_RTYPE   = 3'd1,
      C_LDUR    = 3'd2,
      C_STUR    = 3'd3,
      C_B       = 3'd4,
      C_CBZ     = 3'd5
   } iclass_e;

   // Opcode fields: 11-bit R/D formats on bits 31:21, B on 31:26, CBZ on 31:24
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [5:0]  OP_B    = 6'b000101;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;

   localparam logic [3:0] ALU_ADD    = 4'b0010;
   localparam logic [3:0] ALU_SUB    = 4'b0110;
   localparam logic [3:0] ALU_AND    = 4'b0000;
   localparam logic [3:0] ALU_ORR    = 4'b0001;
   localparam logic [3:0] ALU_PASS_B = 4'b0111;

   localparam logic [1:0] EXT_D   = 2'b00;
   localparam logic [1:0] EXT_B   = 2'b01;
   localparam logic [1:0] EXT_CBZ = 2'b10;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;

   typedef struct packed {
      iclass_e    cls;
      logic [3:0] alu_ctl;
      logic [1:0] ext_sel;
      logic       reg2loc;
   } dec_t;

endpackage

// File: rtl/legv8_multicycle_ctrl_decode.sv
// Combinational opcode classifier: instruction class plus the datapath
// selects that stay fixed for the whole instruction.
module legv8_decode
   import legv8_ctrl_pkg::*;
(
   input  logic [10:0] op_i,   // instr[31:21]; B and CBZ use its upper bits
   output dec_t        dec_o
);

   // Classify the opcode; anything unmatched stays illegal with zero selects
   always_comb begin
      dec_o = '{cls: C_ILLEGAL, alu_ctl: ALU_AND, ext_sel: EXT_D, reg2loc: 1'b0};
      case (op_i)
         OP_ADD:  dec_o = '{cls: C_RTYPE, alu_ctl: ALU_ADD, ext_sel: EXT_D, reg2loc: 1'b0};
         OP_SUB:  dec_o = '{cls: C_RTYPE, alu_ctl: ALU_SUB, ext_sel: EXT_D, reg2loc: 1'b0};
         OP_AND:  dec_o = '{cls: C_RTYPE, alu_ctl: ALU_AND, ext_sel: EXT_D, reg2loc: 1'b0};
         OP_ORR:  dec_o = '{cls: C_RTYPE, alu_ctl: ALU_ORR, ext_sel: EXT_D, reg2loc: 1'b0};
         OP_LDUR: dec_o = '{cls: C_LDUR,  alu_ctl: ALU_ADD, ext_sel: EXT_D, reg2loc: 1'b0};
         // Store data comes from Rt, so port 2 reads bits 4:0
         OP_STUR: dec_o = '{cls: C_STUR,  alu_ctl: ALU_ADD, ext_sel: EXT_D, reg2loc: 1'b1};
         default: begin
            if (op_i[10:5] == OP_B)
               dec_o = '{cls: C_B, alu_ctl: ALU_AND, ext_sel: EXT_B, reg2loc: 1'b0};
            else if (op_i[10:3] == OP_CBZ)
               dec_o = '{cls: C_CBZ, alu_ctl: ALU_PASS_B, ext_sel: EXT_CBZ, reg2loc: 1'b1};
         end
      endcase
   end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multi-cycle control FSM: sequences fetch/decode/execute/memory/
// writeback, drives all datapath selects and flags illegal ops and bus timeouts.
module legv8_multicycle_ctrl
   import legv8_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 255,
   parameter int CNT_W      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic [1:0]  ext_sel,
   output logic [3:0]  alu_ctl,
   output logic        alu_src_b,
   output logic        reg2loc,
   output logic        reg_we,
   output logic        mem_to_reg,
   output logic        retire,
   output logic        illegal,
   output logic        bus_err,
   output logic [3:0]  state_o
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q;
   logic [3:0]       alu_q;
   logic [1:0]       ext_q;
   logic             r2l_q;
   logic             is_ld_q;
   logic             illegal_q, bus_err_q;
   dec_t             dec;
   logic             in_mem, timeout, held;
   state_e           next_issue;
   logic             unused_instr_bits;

   // Operand fields are consumed by the datapath, not by the controller
   assign unused_instr_bits = ^instr[20:0];

   legv8_decode u_dec (
      .op_i  (instr[31:21]),
      .dec_o (dec)
   );

   assign in_mem     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   // Ready arriving in the limit cycle wins over the timeout
   assign timeout    = in_mem && !mem_ready && (wait_cnt_q == CNT_W'(WAIT_LIMIT));
   assign next_issue = run ? S_FETCH : S_IDLE;

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (run) state_d = S_FETCH;
         S_FETCH:     if (mem_ready) state_d = S_DECODE;
                      else if (timeout) state_d = S_TRAP;
         S_DECODE: begin
            case (dec.cls)
               C_RTYPE:       state_d = S_EXEC_R;
               C_LDUR, C_STUR: state_d = S_EXEC_ADDR;
               C_B:           state_d = S_BRANCH;
               C_CBZ:         state_d = S_CBZ_EVAL;
               default:       state_d = S_TRAP;
            endcase
         end
         S_EXEC_R:    state_d = S_WB_R;
         S_WB_R:      state_d = next_issue;
         S_EXEC_ADDR: state_d = is_ld_q ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:    if (mem_ready) state_d = S_WB_LD;
                      else if (timeout) state_d = S_TRAP;
         S_WB_LD:     state_d = next_issue;
         S_MEM_WR:    if (mem_ready) state_d = next_issue;
                      else if (timeout) state_d = S_TRAP;
         S_BRANCH:    state_d = next_issue;
         S_CBZ_EVAL:  state_d = next_issue;
         S_TRAP:      state_d = S_TRAP;
         default:     state_d = S_IDLE;
      endcase
   end

   // State, wait counter, per-instruction selects captured in DECODE, sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         alu_q      <= '0;
         ext_q      <= '0;
         r2l_q      <= 1'b0;
         is_ld_q    <= 1'b0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_d != state_q) &&
             ((state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR)))
            wait_cnt_q <= '0;
         else if (in_mem && !mem_ready && !timeout)
            wait_cnt_q <= wait_cnt_q + 1'b1;
         if (state_q == S_DECODE) begin
            alu_q   <= dec.alu_ctl;
            ext_q   <= dec.ext_sel;
            r2l_q   <= dec.reg2loc;
            is_ld_q <= (dec.cls == C_LDUR);
            if (dec.cls == C_ILLEGAL) illegal_q <= 1'b1;
         end
         if (timeout) bus_err_q <= 1'b1;
      end
   end

   // Moore outputs per state; fetch enables and store retire wait for the handshake.
   // Decoded selects (incl. reg2loc, which STUR needs for store data) stay valid
   // from DECODE until the instruction retires.
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = PC_PLUS4;
      ext_sel      = 2'b00;
      alu_ctl      = 4'b0000;
      alu_src_b    = 1'b0;
      reg2loc      = 1'b0;
      reg_we       = 1'b0;
      mem_to_reg   = 1'b0;
      retire       = 1'b0;
      held = (state_q == S_EXEC_R) || (state_q == S_WB_R) || (state_q == S_EXEC_ADDR) ||
             (state_q == S_MEM_RD) || (state_q == S_WB_LD) || (state_q == S_MEM_WR) ||
             (state_q == S_BRANCH) || (state_q == S_CBZ_EVAL);
      if (state_q == S_DECODE) begin
         alu_ctl = dec.alu_ctl;
         ext_sel = dec.ext_sel;
         reg2loc = dec.reg2loc;
      end else if (held) begin
         alu_ctl = alu_q;
         ext_sel = ext_q;
         reg2loc = r2l_q;
      end
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ready;
            pc_we   = mem_ready;
         end
         S_EXEC_ADDR: alu_src_b = 1'b1;
         S_WB_R: begin
            reg_we = 1'b1;
            retire = 1'b1;
         end
         S_MEM_RD: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
         end
         S_WB_LD: begin
            reg_we     = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
         end
         S_MEM_WR: begin
            mem_req      = 1'b1;
            mem_we       = 1'b1;
            mem_addr_sel = 1'b1;
            retire       = mem_ready;
         end
         S_BRANCH: begin
            pc_we  = 1'b1;
            pc_src = PC_BRANCH;
            retire = 1'b1;
         end
         S_CBZ_EVAL: begin
            pc_we  = zero;
            pc_src = zero ? PC_BRANCH : PC_PLUS4;
            retire = 1'b1;
         end
         default: ;
      endcase
   end

   assign illegal = illegal_q;
   assign bus_err = bus_err_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: a trace model expands each instruction into
// its expected per-cycle output rows; the player drives inputs from the rows and
// compares every cycle, plus literal checks on reset, latency and sticky flags.
module tb_legv8_multicycle_ctrl;
   import legv8_ctrl_pkg::*;

   localparam int LIM = 4;

   logic        clk, rst_n, run, zero, mem_ready;
   logic [31:0] instr;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
   logic [1:0]  pc_src, ext_sel;
   logic [3:0]  alu_ctl, state_o;
   logic        alu_src_b, reg2loc, reg_we, mem_to_reg, retire, illegal, bus_err;

   legv8_multicycle_ctrl #(.WAIT_LIMIT(LIM), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .ext_sel(ext_sel), .alu_ctl(alu_ctl), .alu_src_b(alu_src_b), .reg2loc(reg2loc),
      .reg_we(reg_we), .mem_to_reg(mem_to_reg), .retire(retire), .illegal(illegal),
      .bus_err(bus_err), .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       req, we, asel, irwe, pcwe;
      logic [1:0] pcsrc, ext;
      logic [3:0] alu;
      logic       srcb, r2l, rwe, m2r, ret, ill, berr;
   } out_t;

   typedef struct packed {
      logic [31:0] ins;
      logic        rn, rdy, zr;
      out_t        o;
   } row_t;

   row_t q[$];
   row_t cur;
   out_t act;
   int   checks = 0;
   int   errors = 0;
   bit   ill_s  = 1'b0;
   bit   berr_s = 1'b0;

   assign act = {state_o, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, ext_sel,
                 alu_ctl, alu_src_b, reg2loc, reg_we, mem_to_reg, retire, illegal, bus_err};

   function automatic out_t blank();
      out_t o = '0;
      o.ill  = ill_s;
      o.berr = berr_s;
      return o;
   endfunction

   function automatic void push(input logic [31:0] ins, input logic rn, input logic rdy,
                                input logic zr, input out_t o);
      row_t r;
      r.ins = ins; r.rn = rn; r.rdy = rdy; r.zr = zr; r.o = o;
      q.push_back(r);
   endfunction

   function automatic void idle(input int n, input logic rn);
      out_t o = blank();
      o.st = S_IDLE;
      for (int i = 0; i < n; i++) push(32'h0, rn, 1'b1, 1'b0, o);
   endfunction

   function automatic void trap(input int n);
      out_t o = blank();
      o.st = S_TRAP;
      for (int i = 0; i < n; i++) push(32'h0, 1'b1, 1'b1, 1'b0, o);
   endfunction

   // Expected trace of one instruction: fw/mw are wait cycles before mem_ready
   function automatic void gen(input logic [31:0] ins, input int fw, input int mw,
                               input logic z, input logic rn);
      int         kind = 0;   // 0 illegal, 1 R, 2 LDUR, 3 STUR, 4 B, 5 CBZ
      logic [3:0] alu  = 4'b0000;
      logic [1:0] ext  = 2'b00;
      logic       r2l  = 1'b0;
      out_t       o, h;
      case (ins[31:21])
         11'b10001011000: begin kind = 1; alu = 4'b0010; end
         11'b11001011000: begin kind = 1; alu = 4'b0110; end
         11'b10001010000: begin kind = 1; alu = 4'b0000; end
         11'b10101010000: begin kind = 1; alu = 4'b0001; end
         11'b11111000010: begin kind = 2; alu = 4'b0010; end
         11'b11111000000: begin kind = 3; alu = 4'b0010; r2l = 1'b1; end
         default: begin
            if (ins[31:26] == 6'b000101) begin kind = 4; ext = 2'b01; end
            else if (ins[31:24] == 8'hB4) begin kind = 5; ext = 2'b10; alu = 4'b0111; r2l = 1'b1; end
         end
      endcase
      o = blank(); o.st = S_FETCH; o.req = 1'b1;
      for (int i = 0; i < fw; i++) push(ins, rn, 1'b0, z, o);
      o.irwe = 1'b1; o.pcwe = 1'b1;
      push(ins, rn, 1'b1, z, o);
      h = blank(); h.ext = ext; h.alu = alu; h.r2l = r2l;
      o = h; o.st = S_DECODE;
      push(ins, rn, 1'b1, z, o);
      case (kind)
         1: begin
            o = h; o.st = S_EXEC_R; push(ins, rn, 1'b1, z, o);
            o = h; o.st = S_WB_R; o.rwe = 1'b1; o.ret = 1'b1; push(ins, rn, 1'b1, z, o);
         end
         2, 3: begin
            o = h; o.st = S_EXEC_ADDR; o.srcb = 1'b1; push(ins, rn, 1'b1, z, o);
            o = h; o.req = 1'b1; o.asel = 1'b1;
            if (kind == 2) o.st = S_MEM_RD;
            else begin o.st = S_MEM_WR; o.we = 1'b1; end
            for (int i = 0; i < mw; i++) push(ins, rn, 1'b0, z, o);
            if (kind == 3) o.ret = 1'b1;
            push(ins, rn, 1'b1, z, o);
            if (kind == 2) begin
               o = h; o.st = S_WB_LD; o.rwe = 1'b1; o.m2r = 1'b1; o.ret = 1'b1;
               push(ins, rn, 1'b1, z, o);
            end
         end
         4: begin
            o = h; o.st = S_BRANCH; o.pcwe = 1'b1; o.pcsrc = 2'b01; o.ret = 1'b1;
            push(ins, rn, 1'b1, z, o);
         end
         5: begin
            o = h; o.st = S_CBZ_EVAL; o.pcwe = z; o.pcsrc = z ? 2'b01 : 2'b00; o.ret = 1'b1;
            push(ins, rn, 1'b1, z, o);
         end
         default: begin
            ill_s = 1'b1;
            trap(20);
         end
      endcase
   endfunction

   // Fetch that never sees mem_ready: LIM counted waits, then the limit cycle
   function automatic void gen_timeout();
      out_t o = blank();
      o.st = S_FETCH; o.req = 1'b1;
      for (int i = 0; i <= LIM; i++) push(32'h0, 1'b1, 1'b0, 1'b0, o);
      berr_s = 1'b1;
      trap(5);
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
      end
   endtask

   // Drive each row after the rising edge and compare on the falling edge
   task automatic play(input int n);
      int k = 0;
      while (q.size() > 0 && (n < 0 || k < n)) begin
         cur       = q.pop_front();
         instr     = cur.ins;
         run       = cur.rn;
         mem_ready = cur.rdy;
         zero      = cur.zr;
         @(negedge clk);
         checks++;
         if (act !== cur.o) begin
            errors++;
            $display("FAIL trace t=%0t actual=%h expected=%h", $time, act, cur.o);
         end
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run = 1'b0; mem_ready = 1'b0;
      #1;
      chk("reset_state", {28'h0, state_o}, 32'h0);
      chk("reset_outs", {8'h0, act}, 32'h0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      ill_s  = 1'b0;
      berr_s = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; instr = 32'h0;
      #2;
      chk("por_outs", {8'h0, act}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Hand-computed pins on the model: zero-wait latencies and key selects
      q.delete(); gen(32'h8B030041, 0, 0, 1'b0, 1'b1);
      chk("lat_add", q.size(), 4);
      chk("add_alu", {28'h0, q[2].o.alu}, 32'h2);
      q.delete(); gen(32'hF84080C5, 0, 0, 1'b0, 1'b1);
      chk("lat_ldur", q.size(), 5);
      chk("ldur_srcb", {31'h0, q[2].o.srcb}, 32'h1);
      q.delete(); gen(32'hF80080C5, 0, 0, 1'b0, 1'b1);
      chk("lat_stur", q.size(), 4);
      q.delete(); gen(32'h14000010, 0, 0, 1'b0, 1'b1);
      chk("lat_b", q.size(), 3);
      chk("b_ext", {30'h0, q[1].o.ext}, 32'h1);
      q.delete(); gen(32'hB4000080, 0, 0, 1'b1, 1'b1);
      chk("lat_cbz", q.size(), 3);
      chk("cbz_pcsrc", {30'h0, q[2].o.pcsrc}, 32'h1);
      q.delete();

      // Main instruction stream, including run dropped mid-instruction
      idle(2, 1'b0); idle(1, 1'b1);
      gen(32'h8B030041, 0, 0, 1'b0, 1'b1);   // ADD
      gen(32'hF84080C5, 0, 3, 1'b0, 1'b1);   // LDUR, 3 wait cycles
      gen(32'hF80080C5, 1, 0, 1'b0, 1'b1);   // STUR, fetch wait
      gen(32'hB4000080, 0, 0, 1'b1, 1'b1);   // CBZ taken
      gen(32'hB4000080, 0, 0, 1'b0, 1'b1);   // CBZ not taken
      gen(32'h14000010, 0, 0, 1'b0, 1'b1);   // B
      gen(32'hCB030041, LIM, 0, 1'b0, 1'b1); // SUB, ready in the limit cycle
      gen(32'hF84080C5, 0, LIM, 1'b0, 1'b1); // LDUR, ready in the limit cycle
      gen(32'hAA030041, 0, 0, 1'b0, 1'b1);   // ORR
      gen(32'h8A030041, 0, 0, 1'b0, 1'b0);   // AND with run low throughout
      idle(3, 1'b0);
      play(-1);

      // Fetch timeout
      idle(1, 1'b1);
      gen_timeout();
      play(-1);
      chk("bus_err_sticky", {31'h0, bus_err}, 32'h1);
      do_reset();
      chk("bus_err_cleared", {31'h0, bus_err}, 32'h0);

      // Illegal opcode
      idle(1, 1'b1);
      gen(32'h00000000, 0, 0, 1'b0, 1'b1);
      play(-1);
      chk("illegal_sticky", {31'h0, illegal}, 32'h1);
      do_reset();
      chk("illegal_cleared", {31'h0, illegal}, 32'h0);

      // Asynchronous reset in the middle of a store
      idle(1, 1'b1);
      gen(32'hF80080C5, 0, 3, 1'b0, 1'b1);
      play(5);   // IDLE, FETCH, DECODE, EXEC_ADDR, first MEM_WR
      q.delete();
      mem_ready = 1'b0;
      #1;
      chk("memwr_req_held", {31'h0, mem_req}, 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_req", {31'h0, mem_req}, 32'h0);
      chk("async_rst_state", {28'h0, state_o}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global bound so a stuck run still terminates
   initial begin
      #200000;
      $display("FAIL timeout_watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
